// File: rtl/receiver_link_pkg.sv
// receiver_link_pkg: shared FSM states, parameter defaults and Grant encodings for receiver_link_arbiter
package receiver_link_pkg;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF = 16;
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0 = 2'b01;
  localparam logic [1:0] GRANT_1 = 2'b10;
endpackage

// File: rtl/receiver_link_watchdog.sv
// receiver_link_watchdog: cycle counter that reloads while load is high and flags expiry on its LIMIT-th cycle
module receiver_link_watchdog #(
  parameter int LIMIT = 64,
  localparam int W = $clog2(LIMIT) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? '0 : cnt + 1'b1;
  assign expired = !load && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/receiver_link_arbiter.sv
// receiver_link_arbiter: round-robin share of the module_receiver Req/Ack write link between two senders
// Defining LINK_TIMEOUT_EN adds a SEND-state watchdog that abandons unacknowledged transfers.
import receiver_link_pkg::*;
module receiver_link_arbiter #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [DATA_W-1:0] Entrada0,
  input  logic [DATA_W-1:0] Entrada1,
  output logic              Ack0,
  output logic              Ack1,
  output logic              Req,
  output logic [DATA_W-1:0] Entrada,
  input  logic              Ack,
  output logic [1:0]        Grant,
  output logic [CW-1:0]     WordCount,
  output logic              Full,
  output logic              Timeout
);
  state_t state, state_d;
  logic req_d, ack0_d, ack1_d, full_d, fav, fav_d, clr_pend, pend_d, expired, tmo;
  logic [DATA_W-1:0] ent_d;
  logic [1:0] grant_d;
  logic [CW-1:0] cnt_d;
  assign tmo = state == SEND && !(Req && Ack) && expired;
`ifdef LINK_TIMEOUT_EN
  receiver_link_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk(Clock), .rst_n(Reset), .load(state != SEND), .expired(expired)
  );
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) Timeout <= 1'b0;
    else if (tmo) Timeout <= 1'b1;
`else
  assign expired = 1'b0;
  assign Timeout = 1'b0;
`endif
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      Req <= 1'b0;
      Ack0 <= 1'b0;
      Ack1 <= 1'b0;
      Entrada <= '0;
      Grant <= GRANT_NONE;
      WordCount <= '0;
      Full <= 1'b0;
      fav <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      state <= state_d;
      Req <= req_d;
      Ack0 <= ack0_d;
      Ack1 <= ack1_d;
      Entrada <= ent_d;
      Grant <= grant_d;
      WordCount <= cnt_d;
      Full <= full_d;
      fav <= fav_d;
      clr_pend <= pend_d;
    end
  // fav: 0 favours sender 0, 1 favours sender 1 when both request
  always_comb begin
    state_d = state;
    req_d = Req;
    ack0_d = Ack0;
    ack1_d = Ack1;
    ent_d = Entrada;
    grant_d = Grant;
    cnt_d = WordCount;
    full_d = Full;
    fav_d = fav;
    pend_d = clr_pend;
    case (state)
      IDLE: if (!Full && (Req0 || Req1)) begin
        state_d = SEND;
        grant_d = (Req0 && Req1) ? (fav ? GRANT_1 : GRANT_0) : (Req1 ? GRANT_1 : GRANT_0);
        ent_d = grant_d[1] ? Entrada1 : Entrada0;
      end
      SEND: if (Req && Ack) begin
        state_d = DONE;
        req_d = 1'b0;
        ack0_d = Grant[0];
        ack1_d = Grant[1];
        cnt_d = WordCount == CW'(DEPTH) ? WordCount : WordCount + 1'b1;
        full_d = cnt_d == CW'(DEPTH);
      end else if (tmo) begin
        state_d = IDLE;
        req_d = 1'b0;
        grant_d = GRANT_NONE;
        fav_d = Grant[0];
      end else req_d = 1'b1;
      DONE: if (!(Grant[1] ? Req1 : Req0) && !Ack) begin
        state_d = IDLE;
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        grant_d = GRANT_NONE;
        fav_d = Grant[0];
      end
      default: state_d = IDLE;
    endcase
    // a clear seen during SEND lands on the first cycle after SEND, so it overrides that word's increment
    if (state == SEND) pend_d = clr_pend | Clear;
    else if (Clear || clr_pend) begin
      cnt_d = '0;
      full_d = 1'b0;
      pend_d = 1'b0;
    end
  end
endmodule

// File: tb/tb_receiver_link_arbiter.sv
// tb_receiver_link_arbiter: directed and randomized checks of receiver_link_arbiter against a transaction-level model
module tb_receiver_link_arbiter;
  localparam int DEPTH = 16;
  logic Clock, Reset, Clear, Req0, Req1, Ack0, Ack1, Req, Ack, Full, Timeout;
  logic [15:0] Entrada0, Entrada1, Entrada;
  logic [1:0] Grant;
  logic [4:0] WordCount;
  int n_chk = 0, n_fail = 0;
  logic rx_on, rnd_lat;
  logic [15:0] q0[$], q1[$];
  int served[$];
  int mcnt, lat, lc;
  logic [1:0] pg;
  logic pa, fav, pend, r0_s, r1_s, clr_s, in_send, w, s, done;

  receiver_link_arbiter dut (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .Req0(Req0), .Req1(Req1),
    .Entrada0(Entrada0), .Entrada1(Entrada1), .Ack0(Ack0), .Ack1(Ack1), .Req(Req),
    .Entrada(Entrada), .Ack(Ack), .Grant(Grant), .WordCount(WordCount), .Full(Full),
    .Timeout(Timeout)
  );

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // four-phase transfer of one word from sender sn; the expected word joins that sender's queue
  task automatic send(input int sn, input logic [15:0] d);
    int t;
    if (sn == 0) begin q0.push_back(d); Entrada0 = d; Req0 = 1; end
    else begin q1.push_back(d); Entrada1 = d; Req1 = 1; end
    for (t = 0; t < 600 && !(sn == 0 ? Ack0 : Ack1); t++) @(negedge Clock);
    chk("ackN_rise_wait", t >= 600, 0);
    @(negedge Clock);
    if (sn == 0) Req0 = 0; else Req1 = 0;
    for (t = 0; t < 600 && (sn == 0 ? Ack0 : Ack1); t++) @(negedge Clock);
    chk("ackN_fall_wait", t >= 600, 0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 0;
    @(negedge Clock);
    Reset = 1;
  endtask

  // receiver: acknowledges lat cycles after seeing Req, releases Ack once Req drops
  initial begin
    Ack = 0;
    lc = 0;
    lat = 3;
    forever begin
      @(negedge Clock);
      if (!Req) begin
        Ack = 0;
        lc = 0;
      end else if (rx_on && !Ack) begin
        if (lc >= lat) begin
          Ack = 1;
          lat = rnd_lat ? int'($urandom_range(0, 4)) : 3;
        end else lc++;
      end
    end
  end

  always @(posedge Clock) begin
    r0_s <= Req0;
    r1_s <= Req1;
    clr_s <= Clear;
  end

  // reference model: per-sender word order, round-robin favour after each release, saturating count with deferred clear
  initial begin
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        mcnt = 0; fav = 0; pend = 0; pg = 0; pa = 0;
        q0.delete(); q1.delete();
      end else begin
        in_send = pg != 0 && !pa;
        if ((clr_s || pend) && !in_send) begin mcnt = 0; pend = 0; end
        else if (clr_s) pend = 1;
        if (pg == 0 && Grant != 0) begin
          w = (r0_s && r1_s) ? fav : r1_s;
          chk("grant_owner", Grant, w ? 2'b10 : 2'b01);
          chk("grant_while_full", mcnt == DEPTH, 0);
        end
        if (!pa && (Ack0 || Ack1)) begin
          s = Ack1;
          chk("ackN_matches_grant", {Ack1, Ack0}, Grant);
          chk("word_expected", (s ? q1.size() : q0.size()) == 0, 0);
          if (s && q1.size() > 0) chk("entrada_s1", Entrada, q1.pop_front());
          if (!s && q0.size() > 0) chk("entrada_s0", Entrada, q0.pop_front());
          served.push_back(int'(s));
          mcnt = mcnt == DEPTH ? DEPTH : mcnt + 1;
        end
        if (pg != 0 && Grant == 0) fav = pg[0];
        chk("word_count", WordCount, mcnt);
        chk("full_flag", Full, mcnt == DEPTH);
        pg = Grant;
        pa = Ack0 | Ack1;
      end
    end
  end

  initial begin
    int t;
    Reset = 0; Clear = 0; Req0 = 0; Req1 = 0; Entrada0 = 0; Entrada1 = 0;
    rx_on = 1; rnd_lat = 0; done = 0;
    repeat (3) @(negedge Clock);
    chk("rst_req", Req, 0);
    chk("rst_ack", {Ack1, Ack0}, 0);
    chk("rst_grant", Grant, 0);
    chk("rst_entrada", Entrada, 0);
    chk("rst_count", WordCount, 0);
    chk("rst_full", Full, 0);
    chk("rst_timeout", Timeout, 0);
    Reset = 1;
    send(0, 16'h3000);
    chk("single_entrada", Entrada, 16'h3000);
    chk("single_count", WordCount, 1);
    chk("single_grant_idle", Grant, 0);
    do_reset();
    served.delete();
    fork
      send(0, 16'hA000);
      send(1, 16'hB000);
    join
    send(0, 16'hA001);
    chk("rr_served_n", served.size(), 3);
    if (served.size() == 3) begin
      chk("rr_first", served[0], 0);
      chk("rr_second", served[1], 1);
      chk("rr_third", served[2], 0);
    end
    do_reset();
    for (int i = 0; i < 16; i++) send(0, 16'h3000 + 16'(i));
    chk("fill_full", Full, 1);
    chk("fill_count", WordCount, 16);
    fork
      send(0, 16'h3010);
      begin
        repeat (20) @(negedge Clock);
        chk("full_no_req", Req, 0);
        chk("full_no_grant", Grant, 0);
        Clear = 1;
        @(negedge Clock);
        Clear = 0;
      end
    join
    chk("after_clear_count", WordCount, 1);
    chk("after_clear_data", Entrada, 16'h3010);
    Entrada0 = 16'h5555;
    Req0 = 1;
    for (t = 0; t < 50 && !Req; t++) @(negedge Clock);
    chk("mid_req_seen", Req, 1);
    Reset = 0;
    #1;
    chk("mid_rst_req", Req, 0);
    chk("mid_rst_ack0", Ack0, 0);
    chk("mid_rst_grant", Grant, 0);
    chk("mid_rst_count", WordCount, 0);
    Req0 = 0;
    @(negedge Clock);
    Reset = 1;
    for (int i = 0; i < 4; i++) send(0, 16'h4000 + 16'(i));
    fork
      send(0, 16'h4004);
      begin
        for (t = 0; t < 50 && !Req; t++) @(negedge Clock);
        Clear = 1;
        @(negedge Clock);
        Clear = 0;
        for (t = 0; t < 50 && !Ack0; t++) @(negedge Clock);
        chk("clr_send_count_5", WordCount, 5);
        @(negedge Clock);
        chk("clr_send_count_0", WordCount, 0);
      end
    join
    do_reset();
    rnd_lat = 1;
    fork
      begin
        fork
          for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            send(0, {1'b0, 15'($urandom)});
          end
          for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            send(1, {1'b1, 15'($urandom)});
          end
        join
        done = 1;
      end
      while (!done) begin
        @(negedge Clock);
        Clear = Full && $urandom_range(0, 2) == 0;
      end
    join
    Clear = 0;
    rnd_lat = 0;
`ifdef LINK_TIMEOUT_EN
    do_reset();
    rx_on = 0;
    fork
      send(0, 16'hC000);
      begin
        @(negedge Clock);
        send(1, 16'hD000);
      end
      begin
        for (t = 0; t < 300 && !Timeout; t++) @(negedge Clock);
        chk("tmo_flag", Timeout, 1);
        chk("tmo_req_low", Req, 0);
        chk("tmo_count", WordCount, 0);
        for (t = 0; t < 20 && Grant == 0; t++) @(negedge Clock);
        chk("tmo_next_grant", Grant, 2'b10);
        rx_on = 1;
      end
    join
    chk("tmo_sticky", Timeout, 1);
    chk("tmo_final_count", WordCount, 2);
`endif
    repeat (3) @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
